// File: rtl/ifid_queue.sv
// ifid_queue: instruction queue between fetch and decode.
// Buffers {pc, instr} pairs from fetch in a circular buffer. The oldest pair
// is presented to decode through a valid/ready handshake. Fetch is throttled
// early enough that its single in-flight pair always has a free slot. A taken
// branch (flush) discards every queued and incoming pair.
module ifid_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       fetch_valid,
    input  logic [31:0]                fetch_instr,
    input  logic [31:0]                fetch_pc,
    output logic                       fetch_enable,
    output logic                       id_valid,
    output logic [31:0]                id_instr,
    output logic [31:0]                id_pc,
    input  logic                       id_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] CNT_FULL     = CW'(DEPTH);
    // One slot is kept in reserve for the pair fetch already has in flight.
    localparam logic [CW-1:0] CNT_THROTTLE = CW'(DEPTH - 2);

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          pop;
    logic          push;
    logic          drop;
    logic [63:0]   head;

    // Handshake qualification; flush suppresses both sides of the queue.
    always_comb begin
        pop  = id_valid & id_ready & ~flush;
        push = fetch_valid & ~flush & ((count < CNT_FULL) | pop);
        drop = fetch_valid & ~flush & (count == CNT_FULL) & ~pop;
    end

    // Head presentation and fetch throttle, both from registered state.
    always_comb begin
        head         = mem[rd_ptr];
        id_valid     = (count != '0);
        id_instr     = id_valid ? head[31:0]  : NOP_INSTR;
        id_pc        = id_valid ? head[63:32] : 32'h0;
        fetch_enable = ~flush & (count <= CNT_THROTTLE);
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {fetch_pc, fetch_instr};
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err <= 1'b0;
        end else if (drop) begin
            overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ifid_queue.sv
// Directed testbench for ifid_queue (DEPTH=4). Each table row drives inputs
// on the falling edge and checks the outputs 1ns later, i.e. the outputs
// produced by the state left by earlier rows together with this row's inputs.
module tb_ifid_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_enable;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    logic [2:0]  count;
    logic        overflow_err;

    int checks   = 0;
    int failures = 0;

    ifid_queue #(.DEPTH(4), .NOP_INSTR(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .fetch_valid  (fetch_valid),
        .fetch_instr  (fetch_instr),
        .fetch_pc     (fetch_pc),
        .fetch_enable (fetch_enable),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_ready     (id_ready),
        .count        (count),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        fv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rdy;
        logic [2:0]  cnt;
        logic        vld;
        logic [31:0] idpc;
        logic [31:0] idinstr;
        logic        fe;
        logic        ovf;
    } vec_t;

    localparam int NV = 43;
    vec_t tbl [NV];

    function automatic vec_t mk(logic r, logic f, logic fv, logic [31:0] pc,
                                logic [31:0] ins, logic rdy, logic [2:0] cnt,
                                logic vld, logic [31:0] idpc, logic [31:0] idins,
                                logic fe, logic ovf);
        vec_t v;
        v.rst = r; v.flush = f; v.fv = fv; v.pc = pc; v.instr = ins; v.rdy = rdy;
        v.cnt = cnt; v.vld = vld; v.idpc = idpc; v.idinstr = idins;
        v.fe = fe; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic fv,
                         input logic [31:0] pc, input logic [31:0] ins,
                         input logic rdy);
        @(negedge clk);
        rst = r; flush = f; fetch_valid = fv; fetch_pc = pc;
        fetch_instr = ins; id_ready = rdy;
        #1;
    endtask

    logic [31:0] exp_q [$];
    int          popped;

    initial begin
        //                rst fl fv pc          instr       rdy cnt vld idpc        idinstr     fe ovf
        // reset then idle
        tbl[0]  = mk(0, 0, 0, 32'h0,   32'h0,   0, 3'd0, 0, 32'h0,   NOP,     1, 0);
        // fill with in-flight slot, then drain
        tbl[1]  = mk(0, 0, 1, 32'h0,   32'hA0,  0, 3'd0, 0, 32'h0,   NOP,     1, 0);
        tbl[2]  = mk(0, 0, 1, 32'h4,   32'hA1,  0, 3'd1, 1, 32'h0,   32'hA0,  1, 0);
        tbl[3]  = mk(0, 0, 1, 32'h8,   32'hA2,  0, 3'd2, 1, 32'h0,   32'hA0,  1, 0);
        tbl[4]  = mk(0, 0, 1, 32'hC,   32'hA3,  0, 3'd3, 1, 32'h0,   32'hA0,  0, 0);
        tbl[5]  = mk(0, 0, 0, 32'h0,   32'h0,   0, 3'd4, 1, 32'h0,   32'hA0,  0, 0);
        tbl[6]  = mk(0, 0, 0, 32'h0,   32'h0,   1, 3'd4, 1, 32'h0,   32'hA0,  0, 0);
        tbl[7]  = mk(0, 0, 0, 32'h0,   32'h0,   1, 3'd3, 1, 32'h4,   32'hA1,  0, 0);
        tbl[8]  = mk(0, 0, 0, 32'h0,   32'h0,   1, 3'd2, 1, 32'h8,   32'hA2,  1, 0);
        tbl[9]  = mk(0, 0, 0, 32'h0,   32'h0,   1, 3'd1, 1, 32'hC,   32'hA3,  1, 0);
        tbl[10] = mk(0, 0, 0, 32'h0,   32'h0,   0, 3'd0, 0, 32'h0,   NOP,     1, 0);
        // full with simultaneous push/pop
        tbl[11] = mk(0, 0, 1, 32'h50,  32'hB0,  0, 3'd0, 0, 32'h0,   NOP,     1, 0);
        tbl[12] = mk(0, 0, 1, 32'h54,  32'hB1,  0, 3'd1, 1, 32'h50,  32'hB0,  1, 0);
        tbl[13] = mk(0, 0, 1, 32'h58,  32'hB2,  0, 3'd2, 1, 32'h50,  32'hB0,  1, 0);
        tbl[14] = mk(0, 0, 1, 32'h5C,  32'hB3,  0, 3'd3, 1, 32'h50,  32'hB0,  0, 0);
        tbl[15] = mk(0, 0, 1, 32'h10,  32'hB4,  1, 3'd4, 1, 32'h50,  32'hB0,  0, 0);
        tbl[16] = mk(0, 0, 0, 32'h0,   32'h0,   1, 3'd4, 1, 32'h54,  32'hB1,  0, 0);
        tbl[17] = mk(0, 0, 0, 32'h0,   32'h0,   1, 3'd3, 1, 32'h58,  32'hB2,  0, 0);
        tbl[18] = mk(0, 0, 0, 32'h0,   32'h0,   1, 3'd2, 1, 32'h5C,  32'hB3,  1, 0);
        tbl[19] = mk(0, 0, 0, 32'h0,   32'h0,   1, 3'd1, 1, 32'h10,  32'hB4,  1, 0);
        tbl[20] = mk(0, 0, 0, 32'h0,   32'h0,   0, 3'd0, 0, 32'h0,   NOP,     1, 0);
        // overflow: forced push while full, sticky across flush
        tbl[21] = mk(0, 0, 1, 32'h60,  32'hC0,  0, 3'd0, 0, 32'h0,   NOP,     1, 0);
        tbl[22] = mk(0, 0, 1, 32'h64,  32'hC1,  0, 3'd1, 1, 32'h60,  32'hC0,  1, 0);
        tbl[23] = mk(0, 0, 1, 32'h68,  32'hC2,  0, 3'd2, 1, 32'h60,  32'hC0,  1, 0);
        tbl[24] = mk(0, 0, 1, 32'h6C,  32'hC3,  0, 3'd3, 1, 32'h60,  32'hC0,  0, 0);
        tbl[25] = mk(0, 0, 1, 32'h20,  32'hD0,  0, 3'd4, 1, 32'h60,  32'hC0,  0, 0);
        tbl[26] = mk(0, 0, 0, 32'h0,   32'h0,   0, 3'd4, 1, 32'h60,  32'hC0,  0, 1);
        tbl[27] = mk(0, 1, 0, 32'h0,   32'h0,   0, 3'd4, 1, 32'h60,  32'hC0,  0, 1);
        tbl[28] = mk(0, 0, 0, 32'h0,   32'h0,   0, 3'd0, 0, 32'h0,   NOP,     1, 1);
        // flush with simultaneous fetch and decode traffic
        tbl[29] = mk(0, 0, 1, 32'h70,  32'hE0,  0, 3'd0, 0, 32'h0,   NOP,     1, 1);
        tbl[30] = mk(0, 0, 1, 32'h74,  32'hE1,  0, 3'd1, 1, 32'h70,  32'hE0,  1, 1);
        tbl[31] = mk(0, 0, 1, 32'h78,  32'hE2,  0, 3'd2, 1, 32'h70,  32'hE0,  1, 1);
        tbl[32] = mk(0, 1, 1, 32'h40,  32'hF0,  1, 3'd3, 1, 32'h70,  32'hE0,  0, 1);
        tbl[33] = mk(0, 0, 0, 32'h0,   32'h0,   0, 3'd0, 0, 32'h0,   NOP,     1, 1);
        tbl[34] = mk(0, 0, 1, 32'h100, 32'hF1,  0, 3'd0, 0, 32'h0,   NOP,     1, 1);
        tbl[35] = mk(0, 0, 0, 32'h0,   32'h0,   0, 3'd1, 1, 32'h100, 32'hF1,  1, 1);
        tbl[36] = mk(0, 0, 0, 32'h0,   32'h0,   1, 3'd1, 1, 32'h100, 32'hF1,  1, 1);
        tbl[37] = mk(0, 0, 0, 32'h0,   32'h0,   0, 3'd0, 0, 32'h0,   NOP,     1, 1);
        // reset mid-operation with flush and traffic also asserted
        tbl[38] = mk(0, 0, 1, 32'h80,  32'hA8,  0, 3'd0, 0, 32'h0,   NOP,     1, 1);
        tbl[39] = mk(0, 0, 1, 32'h84,  32'hA9,  0, 3'd1, 1, 32'h80,  32'hA8,  1, 1);
        tbl[40] = mk(1, 1, 1, 32'h88,  32'hAA,  1, 3'd2, 1, 32'h80,  32'hA8,  0, 1);
        tbl[41] = mk(0, 0, 0, 32'h0,   32'h0,   0, 3'd0, 0, 32'h0,   NOP,     1, 0);
        tbl[42] = mk(0, 0, 0, 32'h0,   32'h0,   0, 3'd0, 0, 32'h0,   NOP,     1, 0);

        rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_pc = '0;
        fetch_instr = '0; id_ready = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].flush, tbl[i].fv, tbl[i].pc,
                  tbl[i].instr, tbl[i].rdy);
            chk("count",        i, 32'(count),        32'(tbl[i].cnt));
            chk("id_valid",     i, 32'(id_valid),     32'(tbl[i].vld));
            chk("id_pc",        i, id_pc,             tbl[i].idpc);
            chk("id_instr",     i, id_instr,          tbl[i].idinstr);
            chk("fetch_enable", i, 32'(fetch_enable), 32'(tbl[i].fe));
            chk("overflow_err", i, 32'(overflow_err), 32'(tbl[i].ovf));
        end

        // Pointer wrap: ten back-to-back pushes with decode always ready.
        popped = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 10) begin
                drive(0, 0, 1, 32'h200 + 32'(c) * 4, 32'h1000 + 32'(c), 1);
            end else begin
                drive(0, 0, 0, 32'h0, 32'h0, 1);
            end
            chk("wrap_valid", 100 + c, 32'(id_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("wrap_pc", 100 + c, id_pc, exp_q.pop_front());
                popped++;
            end
            if (c < 10) begin
                exp_q.push_back(32'h200 + 32'(c) * 4);
            end
        end
        chk("wrap_popped", 200, 32'(popped), 32'd10);
        chk("wrap_count",  201, 32'(count),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifid_queue.md
Name: ifid_queue

Overview:
- Instruction queue between the fetch stage and decode; it replaces the bare IF/ID pipeline register.
- Buffers {PC, instruction} pairs produced by fetch, which delivers one cycle after the PC is presented.
- Presents the oldest pair to decode with a valid/ready handshake.
- Throttles fetch through fetch_enable and drops all contents when a branch is taken.

Parameters:
- DEPTH, 4, number of entries; power of 2, minimum 2.
- NOP_INSTR, 32'h0000_0013, value driven on id_instr when the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  branch/jump taken (takeBranch); discards all queued and incoming entries.
- fetch_valid  input  1  fetch_instr/fetch_pc hold a fetched pair this cycle.
- fetch_instr  input  32  fetched instruction.
- fetch_pc  input  32  PC of fetch_instr.
- fetch_enable  output  1  drives fetch PC_enable; high = fetch may advance PC.
- id_valid  output  1  head entry valid for decode.
- id_instr  output  32  head instruction; NOP_INSTR when empty.
- id_pc  output  32  head PC; 32'h0 when empty.
- id_ready  input  1  decode accepts the head entry this cycle.
- count  output  $clog2(DEPTH+1)  current occupancy.
- overflow_err  output  1  sticky: a push was dropped because the queue was full.

Behaviour:
- Reset: synchronous active-high. When rst is high at a clk edge: count=0, read/write pointers=0, overflow_err=0.
  - Resulting outputs: id_valid=0, id_instr=NOP_INSTR, id_pc=0, fetch_enable=1.
  - rst overrides flush and all handshakes, including reset asserted mid-operation.
- Storage: circular buffer of DEPTH x 64 bits. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- pop = id_valid & id_ready & !flush.
- push = fetch_valid & !flush & ((count < DEPTH) | pop).
- Full with simultaneous pop: the push is accepted and count stays at DEPTH.
- Dropped push: fetch_valid & !flush & count==DEPTH & !pop. The entry is discarded and overflow_err is set to 1; it stays 1 until rst.
- count_next = count + push - pop. Both increment and decrement in one cycle means count is unchanged.
- Head outputs are combinational from the registered head entry:
  - id_valid = (count != 0).
  - id_instr/id_pc = mem[rd_ptr] when count != 0, else NOP_INSTR / 0.
- Latency: a pair pushed at edge N appears on id_* after edge N when the queue was empty. There is no same-cycle bypass.
- Ordering: strict FIFO; entries reach decode in push order.
- Flush (rst low):
  - At the edge: count=0, rd_ptr=wr_ptr=0; fetch_valid and id_ready in that cycle are ignored.
  - Flush has no effect on overflow_err.
  - In the cycle flush is high, id_valid still reflects the pre-flush head. Decode must qualify its capture with !flush.
- fetch_enable = !flush & (count <= DEPTH-2), combinational from the registered count.
  - Fetch has one cycle of latency, so at most one pair is in flight when fetch_enable drops.
  - A correctly behaving fetch therefore never causes overflow_err.
- No other states exist: the block is a pure FIFO with flush; no FSM beyond the pointers and count.

Test Plan:
1. Reset then idle: hold rst 2 cycles -> count=0, id_valid=0, id_instr=32'h00000013, id_pc=0, fetch_enable=1, overflow_err=0.
2. Fill and drain, DEPTH=4, id_ready=0: push PCs 0x0,0x4,0x8 with instrs 0xA0..0xA2.
   - fetch_enable drops once count=3.
   - Push 0xC/0xA3 from the in-flight slot -> count=4, no overflow_err.
   - Then id_ready=1 -> id_pc sequence 0x0,0x4,0x8,0xC on consecutive cycles, then id_valid=0.
3. Simultaneous push/pop at full: count=4, fetch_valid=1 (pc 0x10) and id_ready=1 -> count stays 4, head advances; after draining, 0x10 is last out. Wrap: repeat 10 pushes/pops, all PCs in order.
4. Overflow: count=4, id_ready=0, force fetch_valid=1 with pc 0x20 -> count=4, 0x20 never emerges, overflow_err=1; still 1 after a flush; cleared only by rst.
5. Flush with simultaneous traffic: count=3, flush=1 with fetch_valid=1 (pc 0x40) and id_ready=1 -> next cycle count=0, id_valid=0.
   - fetch_enable is 0 during the flush cycle and 1 after.
   - Next push pc 0x100 is the first id_pc seen.
6. Reset mid-operation: count=2 with rst and flush both high -> count=0, overflow_err=0; behaviour after release matches scenario 1.
